im_scan_ctrl: RTL and testbench



---
 rtl/im_scan_pkg.sv | 34 +++
 rtl/im_vga_timing.sv | 70 +++++++
 rtl/im_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_im_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/im_scan_pkg.sv
// Shared VGA 640x480@60 timing defaults, colour constants and scan record types
// for the image-memory scan controller.
package im_scan_pkg;

   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int H_TOT_DEF      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOT_DEF      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_BEG_DEF = H_VIS_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF = H_SYNC_BEG_DEF + H_SYNC_DEF;
   localparam int V_SYNC_BEG_DEF = V_VIS_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF = V_SYNC_BEG_DEF + V_SYNC_DEF;

   localparam logic [11:0] COLOR_BLANK = 12'h000;

   // Decode of the current scan position, aligned with pixel_x/pixel_y.
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } scan_raw_t;

   function automatic logic in_window(input int val, input int lo, input int hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/im_vga_timing.sv
// Pixel-tick divider, h/v scan counters and sync/active decode.
module im_vga_timing
   import im_scan_pkg::*;
#(
   parameter int H_VIS   = H_VIS_DEF,
   parameter int H_FP    = H_FP_DEF,
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BP    = H_BP_DEF,
   parameter int V_VIS   = V_VIS_DEF,
   parameter int V_FP    = V_FP_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BP    = V_BP_DEF,
   parameter int PIX_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       tick,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output scan_raw_t  raw,
   output logic       frame_end
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = $clog2(PIX_DIV);

   logic [DIV_W-1:0] div_cnt;
   logic             h_last;
   logic             v_last;

   assign tick      = en && (div_cnt == DIV_W'(PIX_DIV - 1));
   assign h_last    = (h_cnt == 10'(H_TOT - 1));
   assign v_last    = (v_cnt == 10'(V_TOT - 1));
   assign frame_end = tick && h_last && v_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (!en || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
         if (h_last) begin
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
         end
      end
   end

   // Decoded from the registered counters, so it describes the pixel currently addressed.
   always_comb begin
      raw.hs     = !in_window(int'(h_cnt), H_VIS + H_FP, H_VIS + H_FP + H_SYNC);
      raw.vs     = !in_window(int'(v_cnt), V_VIS + V_FP, V_VIS + V_FP + V_SYNC);
      raw.active = (int'(h_cnt) < H_VIS) && (int'(v_cnt) < V_VIS);
   end

endmodule

// File: rtl/im_scan_ctrl.sv
// Image-memory scan controller: VGA scan generation, ROM-latency realignment
// and frame-synchronous image selection with optional slideshow.
module im_scan_ctrl
   import im_scan_pkg::*;
#(
   parameter int H_VIS   = H_VIS_DEF,
   parameter int H_FP    = H_FP_DEF,
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BP    = H_BP_DEF,
   parameter int V_VIS   = V_VIS_DEF,
   parameter int V_FP    = V_FP_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BP    = V_BP_DEF,
   parameter int PIX_DIV = 4,
   parameter int NUM_IMG = 2,
   parameter int ISEL_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ISEL_W-1:0] isel_req,
   input  logic              isel_wr,
   input  logic              auto_en,
   input  logic [7:0]        slide_period,
   input  logic [11:0]       rgb_in,
   output logic [9:0]        pixel_x,
   output logic [9:0]        pixel_y,
   output logic [ISEL_W-1:0] isel,
   output logic              hsync,
   output logic              vsync,
   output logic [11:0]       vga_rgb,
   output logic              frame_start
);

   logic              tick;
   logic              frame_end;
   scan_raw_t         raw;
   logic [ISEL_W-1:0] pending;
   logic [ISEL_W-1:0] pending_nxt;
   logic [7:0]        frame_cnt;
   logic              wr_ok;
   logic              auto_on;
   logic              advance;

   im_vga_timing #(
      .H_VIS  (H_VIS),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_VIS  (V_VIS),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP),
      .PIX_DIV(PIX_DIV)
   ) u_timing (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .tick     (tick),
      .h_cnt    (pixel_x),
      .v_cnt    (pixel_y),
      .raw      (raw),
      .frame_end(frame_end)
   );

   // rgb_in for the addressed pixel settles one clk after the address moves, so
   // capturing it on the following tick keeps colour aligned with the sync decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         vga_rgb     <= COLOR_BLANK;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_end;
         if (!en) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_rgb <= COLOR_BLANK;
         end else if (tick) begin
            hsync   <= raw.hs;
            vsync   <= raw.vs;
            vga_rgb <= raw.active ? rgb_in : COLOR_BLANK;
         end
      end
   end

   assign wr_ok   = isel_wr && ({1'b0, isel_req} < (ISEL_W + 1)'(NUM_IMG));
   assign auto_on = auto_en && (slide_period != 8'd0);
   assign advance = frame_end && auto_on && (frame_cnt == slide_period - 8'd1);

   // A host write always beats the slideshow step landing in the same clk.
   always_comb begin
      pending_nxt = pending;
      if (wr_ok) begin
         pending_nxt = isel_req;
      end else if (advance) begin
         pending_nxt = (pending == ISEL_W'(NUM_IMG - 1)) ? '0 : pending + ISEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         isel      <= '0;
         frame_cnt <= '0;
      end else begin
         pending <= pending_nxt;
         if (frame_end) begin
            isel <= pending_nxt;
         end
         if (!auto_on || advance) begin
            frame_cnt <= '0;
         end else if (frame_end) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_im_scan_ctrl.sv
// Directed bench for im_scan_ctrl using a reduced 16x9 raster so frames are short.
module tb_im_scan_ctrl;

   localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_VIS = 4, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int PIX_DIV = 4;
   localparam int H_TOT = 16, V_TOT = 9;
   localparam int FRAME_TICKS = H_TOT * V_TOT;
   localparam int FRAME_CLK = FRAME_TICKS * PIX_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  isel_req;
   logic        isel_wr;
   logic        auto_en;
   logic [7:0]  slide_period;
   logic [11:0] rgb_in;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [1:0]  isel;
   logic        hsync;
   logic        vsync;
   logic [11:0] vga_rgb;
   logic        frame_start;

   int errors = 0;
   int checks = 0;
   int clk_n  = 0;

   im_scan_ctrl #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .PIX_DIV(PIX_DIV), .NUM_IMG(2), .ISEL_W(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .isel_req(isel_req), .isel_wr(isel_wr),
      .auto_en(auto_en), .slide_period(slide_period), .rgb_in(rgb_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .isel(isel), .hsync(hsync),
      .vsync(vsync), .vga_rgb(vga_rgb), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Image ROM with one clk of read latency; colour encodes the address.
   always @(posedge clk) rgb_in <= {pixel_y[5:0], pixel_x[5:0]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (clk_n=%0d)", tag, obs, expv, clk_n);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " pixel_x"}, 32'(pixel_x), 0);
      chk({tag, " pixel_y"}, 32'(pixel_y), 0);
      chk({tag, " isel"}, 32'(isel), 0);
      chk({tag, " hsync"}, 32'(hsync), 1);
      chk({tag, " vsync"}, 32'(vsync), 1);
      chk({tag, " vga_rgb"}, 32'(vga_rgb), 0);
      chk({tag, " frame_start"}, 32'(frame_start), 0);
   endtask

   // Expected scan outputs derived from the clk count since en rose.
   task automatic check_all();
      int t, p, hp, vp;
      logic ex_hs, ex_vs, ex_fs;
      logic [11:0] ex_rgb;
      t = clk_n / PIX_DIV;
      if (t == 0) begin
         ex_hs = 1'b1; ex_vs = 1'b1; ex_rgb = 12'h000;
      end else begin
         p  = t - 1;
         hp = p % H_TOT;
         vp = (p / H_TOT) % V_TOT;
         ex_hs  = !(hp >= 10 && hp < 13);
         ex_vs  = !(vp >= 5 && vp < 7);
         ex_rgb = (hp < H_VIS && vp < V_VIS) ? 12'((vp << 6) | hp) : 12'h000;
      end
      ex_fs = (clk_n > 0) && (clk_n % PIX_DIV == 0) && (t % FRAME_TICKS == 0);
      chk("scan pixel_x", 32'(pixel_x), 32'(t % H_TOT));
      chk("scan pixel_y", 32'(pixel_y), 32'((t / H_TOT) % V_TOT));
      chk("scan hsync", 32'(hsync), 32'(ex_hs));
      chk("scan vsync", 32'(vsync), 32'(ex_vs));
      chk("scan vga_rgb", 32'(vga_rgb), 32'(ex_rgb));
      chk("scan frame_start", 32'(frame_start), 32'(ex_fs));
   endtask

   task automatic run_checked(input int n);
      repeat (n) begin
         @(posedge clk);
         clk_n++;
         #1;
         check_all();
      end
   endtask

   task automatic run_to(input int target);
      run_checked(target - clk_n);
   endtask

   task automatic write_isel(input logic [1:0] req);
      isel_req = req;
      isel_wr  = 1'b1;
      run_checked(1);
      isel_wr  = 1'b0;
   endtask

   initial begin
      int base;
      logic [1:0] auto_seq [6];
      auto_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};

      rst_n = 1'b0; en = 1'b0; isel_req = '0; isel_wr = 1'b0;
      auto_en = 1'b0; slide_period = 8'd0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("idle en=0");

      // First frame plus a little: timing, blanking, colour alignment, frame_start.
      @(negedge clk) en = 1'b1;
      clk_n = 0;
      run_checked(3);
      chk("before first tick pixel_x", 32'(pixel_x), 0);
      run_checked(1);
      chk("first tick pixel_x", 32'(pixel_x), 1);
      run_to(FRAME_CLK + 1);
      chk("frame_start cleared", 32'(frame_start), 0);

      // Host write mid-frame only takes effect at the boundary.
      run_to(FRAME_CLK + 2 * H_TOT * PIX_DIV + 1);
      write_isel(2'd1);
      run_to(2 * FRAME_CLK - 1);
      chk("isel held mid-frame", 32'(isel), 0);
      run_checked(1);
      chk("isel at boundary", 32'(isel), 1);
      chk("boundary frame_start", 32'(frame_start), 1);

      // Out-of-range request is ignored.
      run_checked(40);
      write_isel(2'd3);
      run_to(3 * FRAME_CLK);
      chk("isel_req=3 ignored", 32'(isel), 1);

      // Write landing on the boundary clk is applied immediately.
      run_to(4 * FRAME_CLK - 1);
      write_isel(2'd0);
      chk("write on boundary", 32'(isel), 0);

      // Slideshow every 3 frames.
      run_checked(50);
      auto_en = 1'b1; slide_period = 8'd3;
      base = 4 * FRAME_CLK;
      for (int k = 1; k <= 6; k++) begin
         run_to(base + k * FRAME_CLK - 1);
         chk("auto pre-boundary", 32'(isel), 32'(k == 1 ? 2'd0 : auto_seq[k - 2]));
         run_checked(1);
         chk("auto sequence", 32'(isel), 32'(auto_seq[k - 1]));
      end

      // Write collides with an auto advance: write wins, slide count restarts.
      run_to(base + 9 * FRAME_CLK - 1);
      write_isel(2'd0);
      chk("write beats advance", 32'(isel), 0);
      run_to(base + 10 * FRAME_CLK);
      chk("restart frame 1", 32'(isel), 0);
      run_to(base + 11 * FRAME_CLK);
      chk("restart frame 2", 32'(isel), 0);
      run_to(base + 12 * FRAME_CLK);
      chk("advance after restart", 32'(isel), 1);
      auto_en = 1'b0; slide_period = 8'd0;

      // Drop en inside the sync window; scan restarts, selection retained.
      base = 17 * FRAME_CLK;
      run_to(base + (5 * H_TOT + 12) * PIX_DIV + 1);
      chk("pre-drop hsync low", 32'(hsync), 0);
      chk("pre-drop vsync low", 32'(vsync), 0);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("en=0 pixel_x", 32'(pixel_x), 0);
      chk("en=0 pixel_y", 32'(pixel_y), 0);
      chk("en=0 vga_rgb", 32'(vga_rgb), 0);
      chk("en=0 isel kept", 32'(isel), 1);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         chk("en=0 hsync", 32'(hsync), 1);
         chk("en=0 vsync", 32'(vsync), 1);
      end
      en = 1'b1;
      clk_n = 0;
      run_to(FRAME_CLK + 24);
      chk("isel after re-enable", 32'(isel), 1);

      // Asynchronous reset between clock edges.
      run_to(701);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async reset");
      @(negedge clk) rst_n = 1'b1;
      clk_n = 0;
      run_checked(300);
      chk("isel after reset", 32'(isel), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
